// File: rtl/ddr_wr_rr_arbiter.sv
// ---------------------------------------------------------------------------
// ddr_wr_rr_arbiter
//
// Round-robin write arbiter that shares one DDR write controller between four
// write slaves. An eligible slave (request high, non-zero length) is granted,
// its start address and burst length are latched, a write command is
// handshaked with the controller, and the slave's FIFO read data is then muxed
// onto the DDR read-data bus until the controller reports the burst finished.
// A watchdog abandons any grant that lasts TIMEOUT_CYC cycles.
//
// Ports
//   ddr_clk           in   clock, rising edge
//   sys_rstn          in   asynchronous active-low reset
//   Wslave_req  [3:0] in   per-slave write request (level)
//   Wslave_addr [99:0] in  packed 25-bit start addresses, slave i at [25i+24:25i]
//   Wslave_len  [39:0] in  packed 10-bit burst lengths,   slave i at [10i+9:10i]
//   Wslave_data [127:0] in packed 32-bit FIFO data,      slave i at [32i+31:32i]
//   Wslave_ren  [3:0] out  per-slave FIFO read enable
//   grant       [3:0] out  one-hot active grant, 0 when idle
//   ready             in   controller can accept a command
//   mem_wen           out  write command strobe
//   mem_wen_valid     in   controller accepted mem_wen
//   arb_wddr_addr [24:0] out latched address of granted slave
//   arb_wddr_len  [9:0]  out latched length of granted slave
//   ddr_Rfifo_en      in   DDR side pulls one beat
//   ddr_Rfifo_data [31:0] out beat data from granted slave
//   ddr_write_finish  in   single-cycle pulse, burst written
//   timeout_err       out  single-cycle pulse on watchdog expiry
// ---------------------------------------------------------------------------
module ddr_wr_rr_arbiter #(
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic         ddr_clk,
    input  logic         sys_rstn,
    input  logic [3:0]   Wslave_req,
    input  logic [99:0]  Wslave_addr,
    input  logic [39:0]  Wslave_len,
    input  logic [127:0] Wslave_data,
    output logic [3:0]   Wslave_ren,
    output logic [3:0]   grant,
    input  logic         ready,
    output logic         mem_wen,
    input  logic         mem_wen_valid,
    output logic [24:0]  arb_wddr_addr,
    output logic [9:0]   arb_wddr_len,
    input  logic         ddr_Rfifo_en,
    output logic [31:0]  ddr_Rfifo_data,
    input  logic         ddr_write_finish,
    output logic         timeout_err
);

    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        XFER
    } state_t;

    state_t          state;
    logic [1:0]      last_grant;
    logic [1:0]      grant_idx;
    logic [9:0]      beat_cnt;
    logic [WD_W-1:0] watchdog;

    logic [24:0]     slave_addr [4];
    logic [9:0]      slave_len  [4];
    logic [31:0]     slave_data [4];
    logic [3:0]      eligible;
    logic            pick_valid;
    logic [1:0]      pick_idx;
    logic            beat_ok;

    // Unpack the per-slave buses and qualify requests: a zero-length burst is
    // never eligible, so it can never stall the arbiter.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            slave_addr[i] = Wslave_addr[25*i +: 25];
            slave_len[i]  = Wslave_len[10*i +: 10];
            slave_data[i] = Wslave_data[32*i +: 32];
            eligible[i]   = Wslave_req[i] && (Wslave_len[10*i +: 10] != 10'd0);
        end
    end

    // Round-robin pick. The loop walks from the lowest priority (last_grant
    // itself, offset 4) down to the highest (last_grant+1), so the final
    // assignment that survives is the first eligible slave after last_grant.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = 2'd0;
        for (int k = 4; k >= 1; k--) begin
            if (eligible[2'(last_grant + 2'(k))]) begin
                pick_valid = 1'b1;
                pick_idx   = 2'(last_grant + 2'(k));
            end
        end
    end

    // Beats beyond the latched length are swallowed: no FIFO read, zero data.
    assign beat_ok = (grant != 4'b0) && (beat_cnt < arb_wddr_len);

    always_comb begin
        Wslave_ren = 4'b0;
        if (state == XFER && beat_ok) begin
            Wslave_ren[grant_idx] = ddr_Rfifo_en;
        end
    end

    assign ddr_Rfifo_data = beat_ok ? slave_data[grant_idx] : 32'd0;

    // Main controller. Finish is tested before the watchdog in XFER so that a
    // burst completing on the expiry cycle is treated as a clean finish.
    always_ff @(posedge ddr_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            state         <= IDLE;
            last_grant    <= 2'd3;
            grant_idx     <= 2'd0;
            grant         <= 4'b0;
            mem_wen       <= 1'b0;
            timeout_err   <= 1'b0;
            arb_wddr_addr <= 25'd0;
            arb_wddr_len  <= 10'd0;
            beat_cnt      <= 10'd0;
            watchdog      <= '0;
        end else begin
            timeout_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        grant         <= 4'b0001 << pick_idx;
                        grant_idx     <= pick_idx;
                        arb_wddr_addr <= slave_addr[pick_idx];
                        arb_wddr_len  <= slave_len[pick_idx];
                        beat_cnt      <= 10'd0;
                        watchdog      <= '0;
                        state         <= CMD;
                    end
                end

                CMD: begin
                    if (watchdog == WD_LAST) begin
                        timeout_err   <= 1'b1;
                        mem_wen       <= 1'b0;
                        grant         <= 4'b0;
                        arb_wddr_addr <= 25'd0;
                        arb_wddr_len  <= 10'd0;
                        beat_cnt      <= 10'd0;
                        watchdog      <= '0;
                        last_grant    <= grant_idx;
                        state         <= IDLE;
                    end else begin
                        watchdog <= watchdog + 1'b1;
                        if (mem_wen) begin
                            if (mem_wen_valid) begin
                                mem_wen <= 1'b0;
                                state   <= XFER;
                            end
                        end else if (ready) begin
                            mem_wen <= 1'b1;
                        end
                    end
                end

                XFER: begin
                    if (ddr_write_finish || (watchdog == WD_LAST)) begin
                        timeout_err   <= !ddr_write_finish;
                        mem_wen       <= 1'b0;
                        grant         <= 4'b0;
                        arb_wddr_addr <= 25'd0;
                        arb_wddr_len  <= 10'd0;
                        beat_cnt      <= 10'd0;
                        watchdog      <= '0;
                        last_grant    <= grant_idx;
                        state         <= IDLE;
                    end else begin
                        watchdog <= watchdog + 1'b1;
                        if (Wslave_ren != 4'b0) begin
                            beat_cnt <= beat_cnt + 10'd1;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ddr_wr_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ddr_wr_rr_arbiter
//
// Directed bench for ddr_wr_rr_arbiter with TIMEOUT_CYC = 64. Inputs change
// 1 time unit after a rising edge; outputs are sampled in the same window,
// well away from the next edge.
// ---------------------------------------------------------------------------
module tb_ddr_wr_rr_arbiter;

    logic         ddr_clk;
    logic         sys_rstn;
    logic [3:0]   Wslave_req;
    logic [99:0]  Wslave_addr;
    logic [39:0]  Wslave_len;
    logic [127:0] Wslave_data;
    logic [3:0]   Wslave_ren;
    logic [3:0]   grant;
    logic         ready;
    logic         mem_wen;
    logic         mem_wen_valid;
    logic [24:0]  arb_wddr_addr;
    logic [9:0]   arb_wddr_len;
    logic         ddr_Rfifo_en;
    logic [31:0]  ddr_Rfifo_data;
    logic         ddr_write_finish;
    logic         timeout_err;

    int checks;
    int errors;
    int pulses;
    logic [3:0] stray_ren;
    logic       bad_data;
    logic [3:0] exp_grant;

    ddr_wr_rr_arbiter #(.TIMEOUT_CYC(64)) dut (
        .ddr_clk          (ddr_clk),
        .sys_rstn         (sys_rstn),
        .Wslave_req       (Wslave_req),
        .Wslave_addr      (Wslave_addr),
        .Wslave_len       (Wslave_len),
        .Wslave_data      (Wslave_data),
        .Wslave_ren       (Wslave_ren),
        .grant            (grant),
        .ready            (ready),
        .mem_wen          (mem_wen),
        .mem_wen_valid    (mem_wen_valid),
        .arb_wddr_addr    (arb_wddr_addr),
        .arb_wddr_len     (arb_wddr_len),
        .ddr_Rfifo_en     (ddr_Rfifo_en),
        .ddr_Rfifo_data   (ddr_Rfifo_data),
        .ddr_write_finish (ddr_write_finish),
        .timeout_err      (timeout_err)
    );

    initial ddr_clk = 1'b0;
    always #5 ddr_clk = ~ddr_clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Drive the handshake inputs, then let combinational outputs settle.
    task automatic applyStimulus(input logic [3:0] req, input logic rdy, input logic wval,
                                 input logic en, input logic fin);
        Wslave_req       = req;
        ready            = rdy;
        mem_wen_valid    = wval;
        ddr_Rfifo_en     = en;
        ddr_write_finish = fin;
        #1;
    endtask

    task automatic stepClock();
        @(posedge ddr_clk);
        #1;
    endtask

    task automatic setSlave(input int i, input logic [24:0] a, input logic [9:0] l);
        Wslave_addr[25*i +: 25] = a;
        Wslave_len[10*i +: 10]  = l;
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        sys_rstn    = 1'b0;
        Wslave_addr = '0;
        Wslave_len  = '0;
        for (int i = 0; i < 4; i++) begin
            Wslave_data[32*i +: 32] = 32'hA5A5_0000 + 32'(i);
        end
        applyStimulus(4'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        stepClock();
        stepClock();

        // Reset state
        checkOutput("rst_grant", 32'(grant), 32'h0);
        checkOutput("rst_mem_wen", 32'(mem_wen), 32'h0);
        checkOutput("rst_timeout", 32'(timeout_err), 32'h0);
        checkOutput("rst_ren", 32'(Wslave_ren), 32'h0);
        checkOutput("rst_addr", 32'(arb_wddr_addr), 32'h0);
        checkOutput("rst_len", 32'(arb_wddr_len), 32'h0);
        checkOutput("rst_data", ddr_Rfifo_data, 32'h0);

        // Slave 2, addr 0x0001000, len 16; grant on the first edge after reset
        sys_rstn = 1'b1;
        setSlave(2, 25'h0001000, 10'd16);
        applyStimulus(4'b0100, 1'b0, 1'b0, 1'b0, 1'b0);
        stepClock();
        checkOutput("a_grant", 32'(grant), 32'h4);
        checkOutput("a_addr", 32'(arb_wddr_addr), 32'h0001000);
        checkOutput("a_len", 32'(arb_wddr_len), 32'd16);
        checkOutput("a_wen_wait_ready", 32'(mem_wen), 32'h0);
        applyStimulus(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
        stepClock();
        checkOutput("a_wen_rise", 32'(mem_wen), 32'h1);
        stepClock();
        checkOutput("a_wen_hold", 32'(mem_wen), 32'h1);
        applyStimulus(4'b0000, 1'b1, 1'b1, 1'b0, 1'b0);
        stepClock();
        checkOutput("a_wen_fall", 32'(mem_wen), 32'h0);
        applyStimulus(4'b0000, 1'b1, 1'b0, 1'b1, 1'b0);
        pulses    = 0;
        stray_ren = 4'b0;
        bad_data  = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (Wslave_ren[2]) begin
                pulses++;
                if (ddr_Rfifo_data !== 32'hA5A5_0002) bad_data = 1'b1;
            end
            stray_ren = stray_ren | (Wslave_ren & 4'b1011);
            stepClock();
        end
        checkOutput("a_ren_pulses", 32'(pulses), 32'd16);
        checkOutput("a_stray_ren", 32'(stray_ren), 32'h0);
        checkOutput("a_beat_data", 32'(bad_data), 32'h0);
        checkOutput("a_grant_during_xfer", 32'(grant), 32'h4);
        applyStimulus(4'b0000, 1'b1, 1'b0, 1'b0, 1'b1);
        stepClock();
        checkOutput("a_finish_grant", 32'(grant), 32'h0);
        checkOutput("a_finish_addr", 32'(arb_wddr_addr), 32'h0);
        checkOutput("a_finish_len", 32'(arb_wddr_len), 32'h0);

        // Slave 3 len 4 with six pulls: beats 5 and 6 are swallowed
        setSlave(3, 25'h1ABCDEF, 10'd4);
        applyStimulus(4'b1000, 1'b1, 1'b0, 1'b0, 1'b0);
        stepClock();
        checkOutput("d_grant", 32'(grant), 32'h8);
        applyStimulus(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
        stepClock();
        applyStimulus(4'b0000, 1'b1, 1'b1, 1'b0, 1'b0);
        stepClock();
        applyStimulus(4'b0000, 1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            checkOutput($sformatf("d_ren_beat%0d", i + 1), 32'(Wslave_ren),
                        (i < 4) ? 32'h8 : 32'h0);
            checkOutput($sformatf("d_data_beat%0d", i + 1), ddr_Rfifo_data,
                        (i < 4) ? 32'hA5A5_0003 : 32'h0);
            stepClock();
        end
        applyStimulus(4'b0000, 1'b1, 1'b0, 1'b0, 1'b1);
        stepClock();
        checkOutput("d_finish_grant", 32'(grant), 32'h0);

        // All four requesting, len 4: order 0,1,2,3,0 (last grant was 3)
        for (int i = 0; i < 4; i++) setSlave(i, 25'h100 * 25'(i + 1), 10'd4);
        for (int t = 0; t < 5; t++) begin
            exp_grant = 4'b0001 << (t % 4);
            applyStimulus(4'b1111, 1'b1, 1'b0, 1'b0, 1'b0);
            stepClock();
            checkOutput($sformatf("b_order%0d", t), 32'(grant), 32'(exp_grant));
            if (t == 0) begin
                // Inputs changing mid-grant must not disturb latched values
                setSlave(0, 25'h0BEEF, 10'd9);
                applyStimulus(4'b0110, 1'b1, 1'b0, 1'b0, 1'b0);
                checkOutput("b_len_stable", 32'(arb_wddr_len), 32'd4);
                stepClock();
                checkOutput("b_grant_stable", 32'(grant), 32'h1);
                checkOutput("b_addr_stable", 32'(arb_wddr_addr), 32'h100);
                setSlave(0, 25'h100, 10'd4);
            end else begin
                stepClock();
            end
            applyStimulus(4'b1111, 1'b1, 1'b1, 1'b0, 1'b0);
            stepClock();
            applyStimulus(4'b1111, 1'b1, 1'b0, 1'b0, 1'b1);
            stepClock();
            checkOutput($sformatf("b_release%0d", t), 32'(grant), 32'h0);
        end

        // Slave 1 len 0 and slave 3 len 8: only slave 3 is ever granted
        setSlave(1, 25'h222, 10'd0);
        setSlave(3, 25'h333, 10'd8);
        for (int t = 0; t < 2; t++) begin
            applyStimulus(4'b1010, 1'b1, 1'b0, 1'b0, 1'b0);
            stepClock();
            checkOutput($sformatf("c_grant%0d", t), 32'(grant), 32'h8);
            stepClock();
            applyStimulus(4'b1010, 1'b1, 1'b1, 1'b0, 1'b0);
            stepClock();
            applyStimulus(4'b1010, 1'b1, 1'b0, 1'b0, 1'b1);
            stepClock();
        end
        applyStimulus(4'b0010, 1'b1, 1'b0, 1'b0, 1'b0);
        stepClock();
        stepClock();
        stepClock();
        checkOutput("c_zero_len_never", 32'(grant), 32'h0);

        // Watchdog: slave 0 granted, command never accepted
        setSlave(1, 25'h222, 10'd4);
        applyStimulus(4'b0001, 1'b1, 1'b0, 1'b0, 1'b0);
        stepClock();
        checkOutput("e_grant", 32'(grant), 32'h1);
        applyStimulus(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (63) stepClock();
        checkOutput("e_timeout_before", 32'(timeout_err), 32'h0);
        checkOutput("e_wen_before", 32'(mem_wen), 32'h1);
        stepClock();
        checkOutput("e_timeout_pulse", 32'(timeout_err), 32'h1);
        checkOutput("e_timeout_grant", 32'(grant), 32'h0);
        checkOutput("e_timeout_wen", 32'(mem_wen), 32'h0);
        stepClock();
        checkOutput("e_timeout_single", 32'(timeout_err), 32'h0);

        // Finish on the expiry cycle wins; slave 1 is next after slave 0
        applyStimulus(4'b0011, 1'b1, 1'b0, 1'b0, 1'b0);
        stepClock();
        checkOutput("e2_grant", 32'(grant), 32'h2);
        applyStimulus(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
        stepClock();
        applyStimulus(4'b0000, 1'b1, 1'b1, 1'b0, 1'b0);
        stepClock();
        applyStimulus(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (61) stepClock();
        applyStimulus(4'b0000, 1'b1, 1'b0, 1'b0, 1'b1);
        stepClock();
        checkOutput("e2_no_timeout", 32'(timeout_err), 32'h0);
        checkOutput("e2_finish_grant", 32'(grant), 32'h0);
        applyStimulus(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
        stepClock();
        checkOutput("e2_no_late_timeout", 32'(timeout_err), 32'h0);

        // Reset asserted mid-XFER clears everything without a clock edge
        setSlave(2, 25'h0777, 10'd4);
        applyStimulus(4'b0100, 1'b1, 1'b0, 1'b0, 1'b0);
        stepClock();
        checkOutput("f_grant", 32'(grant), 32'h4);
        applyStimulus(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
        stepClock();
        applyStimulus(4'b0000, 1'b1, 1'b1, 1'b0, 1'b0);
        stepClock();
        applyStimulus(4'b0000, 1'b1, 1'b0, 1'b1, 1'b0);
        checkOutput("f_ren_active", 32'(Wslave_ren), 32'h4);
        sys_rstn = 1'b0;
        #1;
        checkOutput("f_rst_grant", 32'(grant), 32'h0);
        checkOutput("f_rst_ren", 32'(Wslave_ren), 32'h0);
        checkOutput("f_rst_addr", 32'(arb_wddr_addr), 32'h0);
        checkOutput("f_rst_len", 32'(arb_wddr_len), 32'h0);
        checkOutput("f_rst_data", ddr_Rfifo_data, 32'h0);
        stepClock();
        sys_rstn = 1'b1;
        applyStimulus(4'b1111, 1'b1, 1'b0, 1'b0, 1'b0);
        stepClock();
        checkOutput("f_rearb_slave0", 32'(grant), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
